// File: rtl/bus_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart_pkg
// Description : Shared register offsets, bit indices and FSM encoding for
//               the memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_uart_pkg;

    // Register offsets, decoded from s_addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_FIFO_CLR = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;
    localparam int STAT_OVF   = 3;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_START = 2'd1;
    localparam logic [1:0] FSM_DATA  = 2'd2;
    localparam logic [1:0] FSM_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bus_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart_tx_if
// Description : biu slave-port bundle for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_uart_tx_if;
    logic        s_we;
    logic [31:0] s_addr;
    logic [3:0]  s_addr_sel;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata;

    modport master (output s_we, output s_addr, output s_addr_sel,
                    output s_wdata, input s_rdata);
    modport slave  (input s_we, input s_addr, input s_addr_sel,
                    input s_wdata, output s_rdata);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous first-word-fall-through FIFO, power-of-2 depth.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic                       clr,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic      [WIDTH-1:0]           rdata,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] c_one   = CW'(1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);
    localparam logic [AW-1:0] c_ptr_one = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rptr];
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push_ok && !clr && !rst) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : bus_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  wire logic   clk,
    input  wire logic   rst,
    bus_uart_tx_if.slave bus,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          r_tx_en;
    logic          r_irq_en;
    logic          r_ovf;
    logic [15:0]   r_baud_div;
    logic [1:0]    r_state;
    logic [15:0]   r_baud_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    logic [1:0]    w_reg;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic          w_wr_tx;
    logic          w_wr_baud;
    logic          w_fifo_clr;
    logic          w_push;
    logic          w_pop;
    logic          w_can_pop;
    logic          w_bit_end;
    logic          w_busy;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_fifo_rdata;
    logic [CW-1:0] w_count;
    logic [15:0]   w_count_ext;
    logic          w_unused;

    assign w_reg       = bus.s_addr[3:2];
    assign w_wr_ctrl   = bus.s_we && (w_reg == REG_CTRL);
    assign w_wr_status = bus.s_we && (w_reg == REG_STATUS);
    assign w_wr_tx     = bus.s_we && (w_reg == REG_TXDATA);
    assign w_wr_baud   = bus.s_we && (w_reg == REG_BAUD);
    assign w_fifo_clr  = w_wr_ctrl && bus.s_addr_sel[0] && bus.s_wdata[CTRL_FIFO_CLR];
    assign w_push      = w_wr_tx && bus.s_addr_sel[0] && !w_fifo_clr;
    assign w_busy      = (r_state != FSM_IDLE);
    assign w_bit_end   = (r_baud_cnt == 16'd0);
    // A clear in the same cycle also blocks the pop so no discarded byte escapes
    assign w_can_pop   = r_tx_en && !w_empty && !w_fifo_clr;
    assign w_pop       = w_can_pop && ((r_state == FSM_IDLE) ||
                                       ((r_state == FSM_STOP) && w_bit_end));
    assign w_count_ext = 16'(w_count);
    assign uart_tx     = r_tx;
    assign tx_irq      = r_irq_en && w_empty && !w_busy;
    assign w_unused    = ^{bus.s_addr[31:4], bus.s_addr[1:0], bus.s_addr_sel[3:2],
                           bus.s_wdata[31:16], w_count_ext[15:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clr   (w_fifo_clr),
        .wdata (bus.s_wdata[7:0]),
        .rdata (w_fifo_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_en    <= 1'b0;
            r_irq_en   <= 1'b0;
            r_ovf      <= 1'b0;
            r_baud_div <= DEFAULT_DIV;
        end else begin
            if (w_wr_ctrl && bus.s_addr_sel[0]) begin
                r_tx_en  <= bus.s_wdata[CTRL_TX_EN];
                r_irq_en <= bus.s_wdata[CTRL_IRQ_EN];
            end
            // Full is judged before any same-cycle pop
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && bus.s_addr_sel[0] && bus.s_wdata[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_baud && bus.s_addr_sel[0]) begin
                r_baud_div[7:0] <= bus.s_wdata[7:0];
            end
            if (w_wr_baud && bus.s_addr_sel[1]) begin
                r_baud_div[15:8] <= bus.s_wdata[15:8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FSM_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
        end else begin
            case (r_state)
                FSM_IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_rdata;
                        r_baud_cnt <= r_baud_div;
                        r_tx       <= 1'b0;
                        r_state    <= FSM_START;
                    end
                end
                FSM_START: begin
                    if (w_bit_end) begin
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= r_baud_div;
                        r_state    <= FSM_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                FSM_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_baud_div;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= FSM_STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift    <= w_fifo_rdata;
                            r_baud_cnt <= r_baud_div;
                            r_tx       <= 1'b0;
                            r_state    <= FSM_START;
                        end else begin
                            r_state <= FSM_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.s_rdata = 32'd0;
        case (w_reg)
            REG_CTRL:   bus.s_rdata = {29'd0, r_irq_en, 1'b0, r_tx_en};
            REG_STATUS: bus.s_rdata = {16'd0, w_count_ext[7:0], 4'd0,
                                       r_ovf, w_empty, w_full, w_busy};
            REG_BAUD:   bus.s_rdata = {16'd0, r_baud_div};
            default:    bus.s_rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_uart_tx
// Description : Self-checking bench: register vectors plus serial-frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_uart_tx;

    localparam logic [31:0] A_CTRL   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_TXDATA = 32'h8;
    localparam logic [31:0] A_BAUD   = 32'hC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic tx_irq;
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_uart_tx_if bus ();

    bus_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .uart_tx (uart_tx),
        .tx_irq  (tx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [31:0] wr_addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rd_addr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
        @(negedge clk);
        bus.s_we       = 1'b1;
        bus.s_addr     = addr;
        bus.s_addr_sel = sel;
        bus.s_wdata    = data;
        @(negedge clk);
        bus.s_we       = 1'b0;
        bus.s_addr     = A_STATUS;
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.s_addr = addr;
        #1;
        check(name, 64'(bus.s_rdata), 64'(exp));
    endtask

    // Expected line level for sample idx of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    logic [63:0] cap;
    logic [63:0] exp_v;
    logic        busy_all;
    logic        irq_seen;
    int          toggles;

    initial begin
        bus.s_we = 1'b0; bus.s_addr = A_STATUS; bus.s_addr_sel = 4'h0; bus.s_wdata = 32'h0;
        vecs[0]  = '{1'b0, A_CTRL,   4'h0, 32'h0,        A_STATUS,      32'h0000_0004};
        vecs[1]  = '{1'b0, A_CTRL,   4'h0, 32'h0,        A_BAUD,        32'h0000_01B1};
        vecs[2]  = '{1'b0, A_CTRL,   4'h0, 32'h0,        A_CTRL,        32'h0000_0000};
        vecs[3]  = '{1'b1, A_BAUD,   4'h1, 32'h0000_00FF, A_BAUD,       32'h0000_01FF};
        vecs[4]  = '{1'b1, A_BAUD,   4'h2, 32'h0000_1200, A_BAUD,       32'h0000_12FF};
        vecs[5]  = '{1'b1, A_BAUD,   4'hF, 32'hABCD_0003, A_BAUD,       32'h0000_0003};
        vecs[6]  = '{1'b1, A_CTRL,   4'h1, 32'h0000_0007, A_CTRL,       32'h0000_0005};
        vecs[7]  = '{1'b1, A_CTRL,   4'h1, 32'h0000_0000, A_CTRL,       32'h0000_0000};
        vecs[8]  = '{1'b1, A_TXDATA, 4'h2, 32'h0000_0055, A_STATUS,     32'h0000_0004};
        vecs[9]  = '{1'b0, A_CTRL,   4'h0, 32'h0,        A_TXDATA,      32'h0000_0000};
        vecs[10] = '{1'b1, A_TXDATA, 4'h1, 32'h0000_0041, 32'h0000_FFF4, 32'h0000_0100};
        vecs[11] = '{1'b1, A_CTRL,   4'h1, 32'h0000_0002, A_STATUS,     32'h0000_0004};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_uart_tx", 64'(uart_tx), 64'd1);
        check("reset_tx_irq", 64'(tx_irq), 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].sel, vecs[i].wdata);
            read_check($sformatf("vec%0d", i), vecs[i].rd_addr, vecs[i].exp);
        end

        // Overflow: nine pushes into an 8-deep FIFO with the transmitter off
        for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 4'h1, 32'(i));
        read_check("ovf_status", A_STATUS, 32'h0000_080A);
        bus_write(A_STATUS, 4'h1, 32'h8);
        read_check("ovf_w1c", A_STATUS, 32'h0000_0802);
        bus_write(A_CTRL, 4'h1, 32'h2);
        read_check("ovf_flush", A_STATUS, 32'h0000_0004);

        // Single frame 0x55 at 4 cycles/bit
        bus_write(A_BAUD, 4'h3, 32'h3);
        bus_write(A_CTRL, 4'h1, 32'h1);
        bus_write(A_TXDATA, 4'h1, 32'h55);
        check("single_latency_idle", 64'(uart_tx), 64'd1);
        cap = '0; exp_v = '0; busy_all = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            cap[i]   = uart_tx;
            exp_v[i] = frame_bit(8'h55, i / 4);
            busy_all = busy_all & bus.s_rdata[0];
        end
        check("single_frame", cap, exp_v);
        check("single_busy", 64'(busy_all), 64'd1);
        @(negedge clk); #1;
        check("single_done_status", 64'(bus.s_rdata), 64'h4);

        // Back-to-back frames at 2 cycles/bit, irq enabled
        bus_write(A_CTRL, 4'h1, 32'h4);
        bus_write(A_BAUD, 4'h3, 32'h1);
        bus_write(A_TXDATA, 4'h1, 32'hA5);
        bus_write(A_TXDATA, 4'h1, 32'h3C);
        check("b2b_irq_pending", 64'(tx_irq), 64'd0);
        bus_write(A_CTRL, 4'h1, 32'h5);
        cap = '0; exp_v = '0; irq_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            cap[i]   = uart_tx;
            exp_v[i] = (i < 20) ? frame_bit(8'hA5, i / 2) : frame_bit(8'h3C, (i - 20) / 2);
            irq_seen = irq_seen | tx_irq;
        end
        check("b2b_frames", cap, exp_v);
        check("b2b_no_early_irq", 64'(irq_seen), 64'd0);
        @(negedge clk); #1;
        check("b2b_idle_status", 64'(bus.s_rdata), 64'h4);
        check("b2b_irq", 64'(tx_irq), 64'd1);

        // Flush mid-frame: first frame completes, queued bytes vanish
        bus_write(A_CTRL, 4'h1, 32'h0);
        for (int i = 0; i < 3; i++) bus_write(A_TXDATA, 4'h1, 32'h11 * (i + 1));
        bus_write(A_CTRL, 4'h1, 32'h1);
        cap = '0; exp_v = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cap[i]   = uart_tx;
            exp_v[i] = (i < 20) ? frame_bit(8'h11, i / 2) : 1'b1;
            if (i == 4) begin
                bus.s_we = 1'b1; bus.s_addr = A_CTRL; bus.s_addr_sel = 4'h1; bus.s_wdata = 32'h3;
            end else begin
                bus.s_we = 1'b0; bus.s_addr = A_STATUS;
            end
        end
        check("flush_frame", cap, exp_v);
        read_check("flush_status", A_STATUS, 32'h0000_0004);

        // Reset during DATA bit 3 of 0xA5 (a low bit)
        bus_write(A_CTRL, 4'h1, 32'h0);
        bus_write(A_BAUD, 4'h3, 32'h3);
        bus_write(A_TXDATA, 4'h1, 32'hA5);
        bus_write(A_TXDATA, 4'h1, 32'h5A);
        bus_write(A_CTRL, 4'h1, 32'h1);
        repeat (18) @(negedge clk);
        check("rst_mid_low", 64'(uart_tx), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_line", 64'(uart_tx), 64'd1);
        read_check("rst_mid_status", A_STATUS, 32'h0000_0004);
        toggles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) toggles++;
        end
        check("rst_mid_quiet", 64'(toggles), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
